// File: rtl/inst_sram_resp.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// inst_sram_resp
// Single-port word SRAM model for an instruction-fetch stage. It accepts one
// request per cycle when ready, responds after a fixed number of cycles, and
// lets the fetch stage cancel a pending read on a branch redirect.
//
// Parameters
//   ADDR_W    word-address width; depth is 2**ADDR_W 32-bit words
//   WAIT_CYC  extra wait cycles per access (0..15); latency = WAIT_CYC + 1
//   INIT_FILE boot image name for the memory
//
// Ports
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset (memory contents are kept)
//   sram_en    request strobe
//   sram_wen   byte write enables, 4'b0000 = read
//   sram_addr  byte address, word index = sram_addr[ADDR_W+1:2]
//   sram_wdata write data, byte i = bits [8i+7:8i]
//   cancel     drops a pending read response
//   sram_rdata read data, holds the last returned word between responses
//   data_ok    one-cycle pulse marking a completed access
//   ready      a new request can be accepted this cycle
//   addr_err   pulses with data_ok for a misaligned access
// -----------------------------------------------------------------------------
module inst_sram_resp #(
   parameter int ADDR_W    = 10,
   parameter int WAIT_CYC  = 0,
   parameter     INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        sram_en,
   input  logic [3:0]  sram_wen,
   input  logic [31:0] sram_addr,
   input  logic [31:0] sram_wdata,
   input  logic        cancel,
   output logic [31:0] sram_rdata,
   output logic        data_ok,
   output logic        ready,
   output logic        addr_err
);

   localparam int          DEPTH   = 2 ** ADDR_W;
   localparam logic [3:0]  LP_WAIT = 4'(WAIT_CYC);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_RESP
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [3:0]          r_cnt;
   logic [3:0]          w_cnt_nxt;
   logic [3:0]          w_cnt_dec;
   logic [ADDR_W-1:0]   r_idx;
   logic                r_is_rd;
   logic                r_misal;
   logic [31:0]         r_hold;
   logic [31:0]         r_mem [DEPTH];

   logic                w_ready;
   logic                w_accept;
   logic                w_drop;
   logic                w_data_ok;
   logic [ADDR_W-1:0]   w_idx;
   logic [31:0]         w_rd_word;

   assign w_idx     = sram_addr[ADDR_W+1:2];
   assign w_ready   = (r_state != S_BUSY);
   assign w_accept  = sram_en & w_ready;
   // A cancel only matters for a read; a write is already committed.
   assign w_drop    = cancel & r_is_rd;
   assign w_data_ok = (r_state == S_RESP) & ~w_drop;
   assign w_rd_word = r_mem[r_idx];
   assign w_cnt_dec = r_cnt - 4'd1;

   // Read data is muxed combinationally in the response cycle so that a
   // same-cycle cancel can still suppress it; r_hold keeps it afterwards.
   assign sram_rdata = (w_data_ok & r_is_rd) ? w_rd_word : r_hold;
   assign data_ok    = w_data_ok;
   assign ready      = w_ready;
   assign addr_err   = w_data_ok & r_misal;

   // NOTE: defaults first so no path through the case leaves a target
   //       unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE, S_RESP: begin
            // A new request in RESP chains straight on, so WAIT_CYC=0
            // streams one word per cycle.
            if (w_accept) begin
               if (LP_WAIT == 4'd0) begin
                  w_state_nxt = S_RESP;
               end else begin
                  w_state_nxt = S_BUSY;
                  w_cnt_nxt   = LP_WAIT;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_BUSY: begin
            if (w_drop) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = 4'd0;
            end else begin
               w_cnt_nxt = w_cnt_dec;
               if (w_cnt_dec == 4'd0) begin
                  w_state_nxt = S_RESP;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   //       samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_idx   <= '0;
         r_is_rd <= 1'b0;
         r_misal <= 1'b0;
         r_hold  <= 32'h0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_idx   <= w_idx;
            r_is_rd <= (sram_wen == 4'b0000);
            r_misal <= (sram_addr[1:0] != 2'b00);
         end
         if (w_data_ok & r_is_rd) begin
            r_hold <= w_rd_word;
         end
      end
   end

   // NOTE: the memory array has no reset; contents survive resetn. Writes
   //       are blocked while resetn is low so nothing commits during reset.
   always_ff @(posedge clk) begin
      if (w_accept && resetn) begin
         for (int b = 0; b < 4; b++) begin
            if (sram_wen[b]) begin
               r_mem[w_idx][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_inst_sram_resp.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_inst_sram_resp
// Drives three instances (WAIT_CYC = 0, 2, 3) with shared inputs. A
// transaction-level model per instance (pending access + cycles remaining)
// predicts ready/data_ok/sram_rdata/addr_err every cycle; directed sections
// pin the model with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_inst_sram_resp;

   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        resetn;
   logic        sram_en;
   logic [3:0]  sram_wen;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic        cancel;

   logic [31:0]   rd  [NI];
   logic [NI-1:0] ok;
   logic [NI-1:0] rdy;
   logic [NI-1:0] err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   generate
      for (genvar g = 0; g < NI; g++) begin : g_dut
         inst_sram_resp #(
            .ADDR_W   (10),
            .WAIT_CYC ((g == 0) ? 0 : ((g == 1) ? 2 : 3)),
            .INIT_FILE("")
         ) u_dut (
            .clk        (clk),
            .resetn     (resetn),
            .sram_en    (sram_en),
            .sram_wen   (sram_wen),
            .sram_addr  (sram_addr),
            .sram_wdata (sram_wdata),
            .cancel     (cancel),
            .sram_rdata (rd[g]),
            .data_ok    (ok[g]),
            .ready      (rdy[g]),
            .addr_err   (err[g])
         );
      end
   endgenerate

   function automatic int wait_of(int i);
      return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
   endfunction

   function automatic logic [31:0] init_word(int i);
      if (i == 5) return 32'h1122_3344;
      return 32'h2408_0001 + 32'(i) * 32'h0101_0101;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h @%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_mem  [NI][16];
   bit          m_pend [NI];
   bit          m_rd   [NI];
   int          m_rem  [NI];
   logic [3:0]  m_idx  [NI];
   bit          m_mis  [NI];
   logic [31:0] m_hold [NI];

   bit          e_rdy  [NI];
   bit          e_ok   [NI];
   logic [31:0] e_rd   [NI];

   initial begin : compare
      for (int i = 0; i < NI; i++) m_hold[i] = 32'h0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            if (!resetn) begin
               m_pend[i] = 1'b0;
               m_hold[i] = 32'h0;
            end
            e_rdy[i] = !(m_pend[i] && m_rem[i] > 0);
            e_ok[i]  = m_pend[i] && m_rem[i] == 0 && !(cancel && m_rd[i]);
            e_rd[i]  = (e_ok[i] && m_rd[i]) ? m_mem[i][m_idx[i]] : m_hold[i];
            check($sformatf("ready%0d", i),    32'(rdy[i]), 32'(e_rdy[i]));
            check($sformatf("data_ok%0d", i),  32'(ok[i]),  32'(e_ok[i]));
            check($sformatf("addr_err%0d", i), 32'(err[i]), 32'(e_ok[i] && m_mis[i]));
            check($sformatf("rdata%0d", i),    rd[i],       e_rd[i]);
         end
         @(posedge clk);
         if (resetn) begin
            for (int i = 0; i < NI; i++) begin
               if (m_pend[i]) begin
                  if (m_rem[i] == 0) begin
                     if (e_ok[i] && m_rd[i]) m_hold[i] = e_rd[i];
                     m_pend[i] = 1'b0;
                  end else if (cancel && m_rd[i]) begin
                     m_pend[i] = 1'b0;
                  end else begin
                     m_rem[i]--;
                  end
               end
               if (sram_en && e_rdy[i]) begin
                  for (int b = 0; b < 4; b++)
                     if (sram_wen[b])
                        m_mem[i][sram_addr[5:2]][8*b +: 8] = sram_wdata[8*b +: 8];
                  m_pend[i] = 1'b1;
                  m_rd[i]   = (sram_wen == 4'b0000);
                  m_idx[i]  = sram_addr[5:2];
                  m_mis[i]  = (sram_addr[1:0] != 2'b00);
                  m_rem[i]  = wait_of(i);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input bit en, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wd, input bit cn);
      @(posedge clk);
      #1;
      sram_en    = en;
      sram_wen   = wen;
      sram_addr  = addr;
      sram_wdata = wd;
      cancel     = cn;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "simulation did not finish");
   end

   initial begin : stim
      logic [31:0] a;
      resetn = 1'b0;
      sram_en = 1'b0; sram_wen = 4'h0; sram_addr = 32'h0; sram_wdata = 32'h0; cancel = 1'b0;

      // reset values
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("rst_ready%0d", i), 32'(rdy[i]), 32'h1);
         check($sformatf("rst_ok%0d", i),    32'(ok[i]),  32'h0);
         check($sformatf("rst_rdata%0d", i), rd[i],       32'h0);
      end
      @(posedge clk); #1 resetn = 1'b1;

      // preload words 0..15 with full-word writes
      for (int w = 0; w < 16; w++) begin
         drive(1'b1, 4'hF, 32'hBFC0_0000 + 32'(w * 4), init_word(w), 1'b0);
         idle(6);
      end

      // single read, WAIT_CYC=0
      drive(1'b1, 4'h0, 32'hBFC0_0000, 32'h0, 1'b0);
      idle(1);
      @(negedge clk);
      check("r032_ok",    32'(ok[0]),  32'h1);
      check("r032_rdata", rd[0],       32'h2408_0001);
      check("r032_ready", 32'(rdy[0]), 32'h1);
      idle(6);

      // streaming reads, WAIT_CYC=0
      drive(1'b1, 4'h0, 32'hBFC0_0000, 32'h0, 1'b0);
      drive(1'b1, 4'h0, 32'hBFC0_0004, 32'h0, 1'b0);
      @(negedge clk);
      check("r033_ok0", 32'(ok[0]), 32'h1);
      check("r033_w0",  rd[0],      32'h2408_0001);
      drive(1'b1, 4'h0, 32'hBFC0_0008, 32'h0, 1'b0);
      @(negedge clk);
      check("r033_ok1", 32'(ok[0]), 32'h1);
      check("r033_w1",  rd[0],      32'h2509_0102);
      idle(1);
      @(negedge clk);
      check("r033_ok2", 32'(ok[0]), 32'h1);
      check("r033_w2",  rd[0],      32'h260A_0203);
      idle(6);

      // WAIT_CYC=3: ready low 3 cycles, sram_en during BUSY dropped
      drive(1'b1, 4'h0, 32'hBFC0_0008, 32'h0, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         drive(1'b1, 4'h0, 32'hBFC0_000C, 32'h0, 1'b0);
         @(negedge clk);
         check($sformatf("r034_busy_ready%0d", k), 32'(rdy[2]), 32'h0);
         check($sformatf("r034_busy_ok%0d", k),    32'(ok[2]),  32'h0);
      end
      idle(1);
      @(negedge clk);
      check("r034_ok",    32'(ok[2]), 32'h1);
      check("r034_rdata", rd[2],      32'h260A_0203);
      idle(1);
      @(negedge clk);
      check("r034_no_queue", 32'(ok[2]), 32'h0);
      idle(6);

      // partial write then read of the same word
      drive(1'b1, 4'b0011, 32'hBFC0_0014, 32'hAABB_CCDD, 1'b0);
      drive(1'b1, 4'h0,    32'hBFC0_0014, 32'h0,         1'b0);
      @(negedge clk);
      check("r035_wr_ok",   32'(ok[0]), 32'h1);
      check("r035_wr_hold", rd[0],      32'h270B_0304);
      idle(1);
      @(negedge clk);
      check("r035_rd_ok", 32'(ok[0]), 32'h1);
      check("r035_rdata", rd[0],      32'h1122_CCDD);
      idle(6);

      // cancel during BUSY, WAIT_CYC=2
      drive(1'b1, 4'h0, 32'hBFC0_0000, 32'h0, 1'b0);
      drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
      check("r036_busy", 32'(rdy[1]), 32'h0);
      idle(1);
      @(negedge clk);
      check("r036_ready", 32'(rdy[1]), 32'h1);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("r036_no_ok%0d", k), 32'(ok[1]), 32'h0);
         check($sformatf("r036_hold%0d", k),  rd[1],      32'h270B_0304);
         idle(1);
         @(negedge clk);
      end
      idle(6);

      // reset during BUSY, then misaligned read after release
      drive(1'b1, 4'h0, 32'hBFC0_0000, 32'h0, 1'b0);
      idle(1);
      drive(1'b1, 4'h0, 32'hBFC0_0006, 32'h0, 1'b0);
      resetn = 1'b0;
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("r037_ready%0d", i), 32'(rdy[i]), 32'h1);
         check($sformatf("r037_ok%0d", i),    32'(ok[i]),  32'h0);
         check($sformatf("r037_err%0d", i),   32'(err[i]), 32'h0);
         check($sformatf("r037_rdata%0d", i), rd[i],       32'h0);
      end
      drive(1'b1, 4'h0, 32'hBFC0_0006, 32'h0, 1'b0);
      resetn = 1'b1;
      idle(1);
      @(negedge clk);
      check("r037_ok_w0",  32'(ok[0]),  32'h1);
      check("r037_err_w0", 32'(err[0]), 32'h1);
      check("r037_rd_w0",  rd[0],       32'h2509_0102);
      idle(3);
      @(negedge clk);
      check("r037_ok_w3",  32'(ok[2]),  32'h1);
      check("r037_err_w3", 32'(err[2]), 32'h1);
      check("r037_rd_w3",  rd[2],       32'h2509_0102);
      idle(6);

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
         if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
         drive($urandom_range(0, 9) < 7,
               ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
               a, $urandom, $urandom_range(0, 6) == 0);
         resetn = ($urandom_range(0, 799) != 0);
      end
      resetn = 1'b1;
      idle(8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
